// File: rtl/ram_dp_tp_be.sv
// ram_dp_tp_be: true dual-port byte-enable RAM with selectable read latency and post-reset clear
module ram_dp_tp_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             busy,
    input  logic                             a_en,
    input  logic                             a_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH-1:0]            a_wdata,
    output logic [DATA_WIDTH-1:0]            a_rdata,
    output logic                             a_rvalid,
    input  logic                             b_en,
    input  logic                             b_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH-1:0]            b_wdata,
    output logic [DATA_WIDTH-1:0]            b_rdata,
    output logic                             b_rvalid,
    output logic                             collision
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp_tp_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_dp_tp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {S_CLEAR, S_READY} state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_busy;
    logic                  w_ready;
    logic                  w_a_wr, w_a_rd, w_b_wr, w_b_rd, w_same;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old, w_a_word, w_b_word;
    logic [DATA_WIDTH-1:0] w_a_rd_word, w_b_rd_word;
    logic [DATA_WIDTH-1:0] r_a_d1, r_b_d1;
    logic                  r_a_v1, r_b_v1;
    logic                  r_coll;

    // FSM state register and clear address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == S_CLEAR) ? r_cnt + ADDR_WIDTH'(1) : '0;
        end
    end

    // Leave CLEAR once the last location has been zeroed
    always_comb begin
        w_state_nxt = (r_state == S_CLEAR && r_cnt == '1) ? S_READY : r_state;
    end

    // FSM outputs: busy while clearing, port requests honoured only when ready
    always_comb begin
        w_busy  = (r_state == S_CLEAR);
        w_ready = ~w_busy & ~rst;
    end

    assign busy    = w_busy;
    assign w_a_wr  = w_ready & a_en & a_we;
    assign w_a_rd  = w_ready & a_en & ~a_we;
    assign w_b_wr  = w_ready & b_en & b_we;
    assign w_b_rd  = w_ready & b_en & ~b_we;
    assign w_same  = (a_addr == b_addr);
    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    // Post-write word per port; on a same-address double write both ports compute the identical A-priority merge
    always_comb begin
        w_a_word = w_a_old;
        w_b_word = w_b_old;
        for (int i = 0; i < NB; i++) begin
            w_a_word[i*BYTE_WIDTH +: BYTE_WIDTH] = a_be[i] ? a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH] :
                (w_b_wr && w_same && b_be[i]) ? b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH] :
                w_a_old[i*BYTE_WIDTH +: BYTE_WIDTH];
            w_b_word[i*BYTE_WIDTH +: BYTE_WIDTH] = (w_a_wr && w_same && a_be[i]) ? a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH] :
                b_be[i] ? b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH] :
                w_b_old[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Read word selection: old contents, or the other port's merged write in write-first mode
    always_comb begin
        w_a_rd_word = (RDW_MODE != 0 && w_b_wr && w_same) ? w_b_word : w_a_old;
        w_b_rd_word = (RDW_MODE != 0 && w_a_wr && w_same) ? w_a_word : w_b_old;
    end

    // Memory array: clear sweep while busy, otherwise port writes
    always_ff @(posedge clk) begin
        if (w_busy && !rst) r_mem[r_cnt] <= '0;
        if (w_a_wr) r_mem[a_addr] <= w_a_word;
        if (w_b_wr) r_mem[b_addr] <= w_b_word;
    end

    // First read stage and collision flag; data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_d1 <= '0;
            r_b_d1 <= '0;
            r_a_v1 <= 1'b0;
            r_b_v1 <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_a_v1 <= w_a_rd;
            r_b_v1 <= w_b_rd;
            if (w_a_rd) r_a_d1 <= w_a_rd_word;
            if (w_b_rd) r_b_d1 <= w_b_rd_word;
            r_coll <= w_a_wr & w_b_wr & w_same & |(a_be & b_be);
        end
    end

    assign collision = r_coll;

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_a_d2, r_b_d2;
        logic                  r_a_v2, r_b_v2;
        // Extra output register stage
        always_ff @(posedge clk) begin
            if (rst) begin
                r_a_d2 <= '0;
                r_b_d2 <= '0;
                r_a_v2 <= 1'b0;
                r_b_v2 <= 1'b0;
            end else begin
                r_a_v2 <= r_a_v1;
                r_b_v2 <= r_b_v1;
                if (r_a_v1) r_a_d2 <= r_a_d1;
                if (r_b_v1) r_b_d2 <= r_b_d1;
            end
        end
        assign a_rdata  = r_a_d2;
        assign a_rvalid = r_a_v2;
        assign b_rdata  = r_b_d2;
        assign b_rvalid = r_b_v2;
    end else begin : g_lat1
        assign a_rdata  = r_a_d1;
        assign a_rvalid = r_a_v1;
        assign b_rdata  = r_b_d1;
        assign b_rvalid = r_b_v1;
    end
endmodule

// File: tb/tb_ram_dp_tp_be.sv
// tb_ram_dp_tp_be: directed vector bench for two RAM builds (latency 1 read-first, latency 2 write-first)
module tb_ram_dp_tp_be;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [3:0]  a_be = '0, a_addr = '0, b_be = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        busy0, a_rv0, b_rv0, coll0, busy1, a_rv1, b_rv1, coll1;
    logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_busy;
    logic        seen;

    always #5 clk = ~clk;

    ram_dp_tp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rd0), .a_rvalid(a_rv0),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rd0), .b_rvalid(b_rv0),
        .collision(coll0));

    ram_dp_tp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rd1), .a_rvalid(a_rv1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rd1), .b_rvalid(b_rv1),
        .collision(coll1));

    typedef struct {
        bit          ae, awe;
        logic [3:0]  abe, aad;
        logic [31:0] awd;
        bit          ben, bwe;
        logic [3:0]  bbe, bad;
        logic [31:0] bwd;
        logic [31:0] ea0, ea1, eb0, eb1;
        bit          ecol;
        string       nm;
    } vec_t;

    vec_t vt[$];
    vec_t v;

    function automatic vec_t mk(bit ae, bit awe, logic [3:0] abe, logic [3:0] aad, logic [31:0] awd,
                                bit ben, bit bwe, logic [3:0] bbe, logic [3:0] bad, logic [31:0] bwd,
                                logic [31:0] ea0, logic [31:0] ea1, logic [31:0] eb0, logic [31:0] eb1,
                                bit ecol, string nm);
        vec_t r;
        r.ae = ae; r.awe = awe; r.abe = abe; r.aad = aad; r.awd = awd;
        r.ben = ben; r.bwe = bwe; r.bbe = bbe; r.bad = bad; r.bwd = bwd;
        r.ea0 = ea0; r.ea1 = ea1; r.eb0 = eb0; r.eb1 = eb1; r.ecol = ecol; r.nm = nm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_en = 1'b0; a_we = 1'b0; a_be = '0;
        b_en = 1'b0; b_we = 1'b0; b_be = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            seen = seen | a_rv0 | b_rv0 | a_rv1 | b_rv1;
            cyc();
        end
    endtask

    task automatic burst(input int n, input bit zero);
        for (int i = 0; i < n + 2; i++) begin
            a_en = (i < n); a_we = 1'b0; a_be = '0; a_addr = 4'(i);
            cyc();
            if (i < n) begin
                chk($sformatf("burst%0d/a_rv0", i), a_rv0, 1);
                chk($sformatf("burst%0d/a_rd0", i), a_rd0, zero ? 32'h0 : 32'hA0 + i);
            end else chk($sformatf("burst%0d/a_rv0_end", i), a_rv0, 0);
            if (i >= 1 && i <= n) begin
                chk($sformatf("burst%0d/a_rv1", i), a_rv1, 1);
                chk($sformatf("burst%0d/a_rd1", i), a_rd1, zero ? 32'h0 : 32'hA0 + i - 1);
            end else chk($sformatf("burst%0d/a_rv1_idle", i), a_rv1, 0);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back(mk(1,1,4'hF,5,32'hDEADBEEF, 0,0,0,0,0, 0,0,0,0, 0, "wr5"));
        vt.push_back(mk(1,0,4'h0,5,0, 0,0,0,0,0, 32'hDEADBEEF,32'hDEADBEEF,0,0, 0, "rd5"));
        vt.push_back(mk(1,1,4'hF,7,32'h11223344, 0,0,0,0,0, 0,0,0,0, 0, "wr7"));
        vt.push_back(mk(0,0,0,0,0, 1,1,4'b0101,7,32'hAABBCCDD, 0,0,0,0, 0, "bwr7_be5"));
        vt.push_back(mk(1,0,4'hF,7,0, 0,0,0,0,0, 32'h11BB33DD,32'h11BB33DD,0,0, 0, "rd7_merged"));
        vt.push_back(mk(1,1,4'hF,3,32'h1, 0,0,0,0,0, 0,0,0,0, 0, "wr3"));
        vt.push_back(mk(1,1,4'hF,3,32'h2, 1,0,0,3,0, 0,0,32'h1,32'h2, 0, "rdw3"));
        vt.push_back(mk(0,0,0,0,0, 1,0,0,3,0, 0,0,32'h2,32'h2, 0, "rd3_after"));
        vt.push_back(mk(1,1,4'hF,9,32'h0, 0,0,0,0,0, 0,0,0,0, 0, "clr9a"));
        vt.push_back(mk(1,1,4'b0011,9,32'h11111111, 1,1,4'b0110,9,32'h22222222, 0,0,0,0, 1, "coll_ovl"));
        vt.push_back(mk(1,0,0,9,0, 0,0,0,0,0, 32'h00221111,32'h00221111,0,0, 0, "rd9_ovl"));
        vt.push_back(mk(1,1,4'hF,9,32'h0, 0,0,0,0,0, 0,0,0,0, 0, "clr9b"));
        vt.push_back(mk(1,1,4'b0011,9,32'h11111111, 1,1,4'b1100,9,32'h22222222, 0,0,0,0, 0, "coll_disj"));
        vt.push_back(mk(0,0,0,0,0, 1,0,0,9,0, 0,0,32'h22221111,32'h22221111, 0, "rd9_disj"));
        vt.push_back(mk(1,1,4'h0,5,32'h0, 0,0,0,0,0, 0,0,0,0, 0, "wr5_be0"));
        vt.push_back(mk(1,0,0,5,0, 1,0,0,5,0, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF, 0, "dual_rd5"));
        vt.push_back(mk(1,0,0,3,0, 1,1,4'hF,2,32'hCAFEF00D, 32'h2,32'h2,0,0, 0, "indep"));
        vt.push_back(mk(1,0,0,9,0, 1,0,0,2,0, 32'h22221111,32'h22221111,32'hCAFEF00D,32'hCAFEF00D, 0, "indep_rd"));
        vt.push_back(mk(1,1,4'hF,12,32'h12345678, 0,0,0,0,0, 0,0,0,0, 0, "wr12"));
        vt.push_back(mk(1,0,0,12,0, 1,1,4'b1100,12,32'hAABB0000, 32'h12345678,32'hAABB5678,0,0, 0, "rdw12_part"));
        vt.push_back(mk(1,0,0,12,0, 0,0,0,0,0, 32'hAABB5678,32'hAABB5678,0,0, 0, "rd12_after"));

        idle();
        seen = 1'b0;
        cyc();
        chk("rst/busy0", busy0, 1);
        chk("rst/busy1", busy1, 1);
        chk("rst/a_rd0", a_rd0, 0);
        chk("rst/b_rd1", b_rd1, 0);
        chk("rst/a_rv0", a_rv0, 0);
        chk("rst/b_rv1", b_rv1, 0);
        chk("rst/coll0", coll0, 0);
        rst = 1'b0;
        a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 0; a_wdata = 32'hFFFFFFFF;
        b_en = 1'b1; b_we = 1'b0; b_addr = 1;
        count_busy(n_busy);
        idle();
        chk("clear/busy_cycles", n_busy, 16);
        chk("clear/busy1_low", busy1, 0);
        cyc();
        cyc();
        seen = seen | a_rv0 | b_rv0 | a_rv1 | b_rv1;
        chk("clear/no_rvalid_while_busy", seen, 0);
        burst(16, 1'b1);

        foreach (vt[k]) begin
            v = vt[k];
            a_en = v.ae; a_we = v.awe; a_be = v.abe; a_addr = v.aad; a_wdata = v.awd;
            b_en = v.ben; b_we = v.bwe; b_be = v.bbe; b_addr = v.bad; b_wdata = v.bwd;
            cyc();
            idle();
            chk({v.nm, "/a_rv0"}, a_rv0, v.ae & ~v.awe);
            chk({v.nm, "/b_rv0"}, b_rv0, v.ben & ~v.bwe);
            if (v.ae && !v.awe) chk({v.nm, "/a_rd0"}, a_rd0, v.ea0);
            if (v.ben && !v.bwe) chk({v.nm, "/b_rd0"}, b_rd0, v.eb0);
            chk({v.nm, "/coll0"}, coll0, v.ecol);
            chk({v.nm, "/coll1"}, coll1, v.ecol);
            chk({v.nm, "/a_rv1_early"}, a_rv1, 0);
            chk({v.nm, "/b_rv1_early"}, b_rv1, 0);
            cyc();
            chk({v.nm, "/a_rv1"}, a_rv1, v.ae & ~v.awe);
            chk({v.nm, "/b_rv1"}, b_rv1, v.ben & ~v.bwe);
            if (v.ae && !v.awe) chk({v.nm, "/a_rd1"}, a_rd1, v.ea1);
            if (v.ben && !v.bwe) chk({v.nm, "/b_rd1"}, b_rd1, v.eb1);
            chk({v.nm, "/a_rv0_pulse"}, a_rv0, 0);
            if (v.ae && !v.awe) chk({v.nm, "/a_rd0_hold"}, a_rd0, v.ea0);
            chk({v.nm, "/coll0_pulse"}, coll0, 0);
        end

        for (int i = 0; i < 5; i++) begin
            a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 4'(i); a_wdata = 32'hA0 + i;
            cyc();
        end
        idle();
        burst(5, 1'b0);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("midclr/busy_before", busy0, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        count_busy(n_busy);
        chk("midclr/busy_cycles", n_busy, 16);
        burst(6, 1'b1);

        a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 1; a_wdata = 32'h55;
        cyc();
        a_we = 1'b0;
        cyc();
        idle();
        chk("inflight/a_rv0", a_rv0, 1);
        chk("inflight/a_rd0", a_rd0, 32'h55);
        chk("inflight/a_rv1_pre", a_rv1, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("inflight/a_rv1_rst", a_rv1, 0);
        chk("inflight/a_rd1_rst", a_rd1, 0);
        chk("inflight/a_rd0_rst", a_rd0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("inflight/a_rv1_after%0d", i), a_rv1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_dp_tp_be.md
Name: ram_dp_tp_be

Overview:
- Parametrised true dual-port RAM: two independent read/write ports on one clock.
- Separate write-data and read-data buses; no tri-state buses.
- Per-byte write enables, selectable read latency, defined cross-port read-during-write and write-write collision behaviour.
- Optional sequential memory clear after reset.
- General on-chip buffer for the FPGA utility library; drop-in for packet buffers, line buffers and mailbox RAMs.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- ADDR_WIDTH, 8: address width; DEPTH = 1 << ADDR_WIDTH.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2; any other value is an elaboration error.
- RDW_MODE, 0: cross-port read-during-write result; 0 = old data (read-first), 1 = new merged data (write-first).
- CLEAR_ON_RESET, 1: 1 = zero every location after reset; 0 = contents untouched by reset.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- busy  output  1  clear sequence in progress; port requests ignored while high
- a_en  input  1  port A request
- a_we  input  1  port A write (1) / read (0)
- a_be  input  NB  port A byte enables, writes only
- a_addr  input  ADDR_WIDTH  port A address
- a_wdata  input  DATA_WIDTH  port A write data
- a_rdata  output  DATA_WIDTH  port A read data
- a_rvalid  output  1  port A read data valid, one-cycle pulse
- b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B
- collision  output  1  registered pulse: both ports wrote the same address with overlapping byte enables

Behaviour:
- Reset (rst high at a clock edge):
  - a_rdata, b_rdata = 0; a_rvalid, b_rvalid = 0; collision = 0.
  - All read pipeline stages flushed.
  - If CLEAR_ON_RESET = 1: FSM goes to CLEAR, clear counter = 0, busy = 1 from the cycle after the reset edge.
  - If CLEAR_ON_RESET = 0: FSM goes to READY, busy = 0.
  - Reset asserted mid-clear restarts the clear at address 0.
- FSM states:
  - CLEAR: write 0 to mem[counter] every cycle, then counter += 1. After the write to DEPTH-1, go to READY. busy drops the cycle after that final write, so the clear takes DEPTH cycles.
  - READY: normal operation.
- While busy = 1: a_en/b_en are ignored. No writes, no reads, no rvalid.
- Write (READY, x_en=1, x_we=1):
  - Each byte lane i with x_be[i]=1 is updated at the clock edge. Other lanes are unchanged.
  - x_be = 0 is a no-op.
  - Writes never produce rvalid.
- Read (READY, x_en=1, x_we=0): x_be is ignored.
  - RD_LATENCY = 1: x_rdata = mem[x_addr] and x_rvalid = 1 on the edge after the request.
  - RD_LATENCY = 2: both appear one edge later, through an extra output register.
  - Back-to-back reads give one result per cycle in request order.
- Idle: x_rdata holds its last value, not zero. x_rvalid = 0.
- Same-port read-during-write cannot occur; x_we selects the operation.
- Cross-port read-during-write (one port writes address X while the other reads X in the same cycle):
  - RDW_MODE = 0: the reader gets the pre-write word.
  - RDW_MODE = 1: the reader gets the post-write word: written lanes new, unwritten lanes old.
- Write-write collision (both ports write address X in the same cycle):
  - Per lane, port A wins where both enable; a lane enabled by only one port takes that port's data.
  - If any lane overlaps, collision = 1 on the next cycle for one cycle; otherwise collision = 0.
- Different addresses: both ports operate fully independently every cycle.
- Address wrap: no out-of-range address exists, since DEPTH = 2^ADDR_WIDTH.
- Two reads of the same address in the same cycle: both ports return the same word.

Test Plan:
1. CLEAR_ON_RESET=1, ADDR_WIDTH=4: pulse rst one cycle → busy=1 for exactly 16 cycles. Port A write 0xFFFFFFFF issued during busy is dropped. After busy falls, reading addr 0..15 returns 0.
2. RD_LATENCY=1, then 2: A writes 0xDEADBEEF to addr 5, be=4'hF; next cycle A reads addr 5 → a_rdata=0xDEADBEEF with a_rvalid pulse exactly 1 or 2 edges after the read request respectively. Five back-to-back reads of addr 0..4 give five consecutive rvalid pulses in order.
3. Byte enables: addr 7 holds 0x11223344; B writes 0xAABBCCDD with be=4'b0101 → a read returns 0x11BB33DD.
4. Cross-port RDW: addr 3 = 0x00000001; same cycle A writes 0x00000002 (be=F) to 3 and B reads 3 → b_rdata=0x00000001 when RDW_MODE=0, 0x00000002 when RDW_MODE=1. A later read returns 0x00000002 in both modes.
5. Collision: addr 9 = 0; same cycle A writes 0x11111111 be=4'b0011, B writes 0x22222222 be=4'b0110 → addr 9 = 0x00221111, collision=1 for one cycle. Repeat with B be=4'b1100 → addr 9 = 0x22221111, collision stays 0.
6. Reset mid-operation: rst asserted at clear counter 6 → counter restarts at 0 and busy stays high 16 more cycles. rst during an in-flight read with RD_LATENCY=2 → no rvalid ever appears for it, a_rdata=0.
